// File: rtl/enemy_controller_pkg.sv
// enemy_controller_pkg: shared state encoding, lane positions and LFSR constants
package enemy_controller_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CRASH, OVER} state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [9:0] LANE0_X = 10'd160;
  localparam logic [9:0] LANE1_X = 10'd260;
  localparam logic [9:0] LANE2_X = 10'd360;
  localparam logic [9:0] LANE3_X = 10'd460;
  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    return sel == 2'd0 ? LANE0_X : sel == 2'd1 ? LANE1_X : sel == 2'd2 ? LANE2_X : LANE3_X;
  endfunction
endpackage

// File: rtl/enemy_lfsr.sv
// enemy_lfsr: free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for lane selection
module enemy_lfsr
  import enemy_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);
  always_ff @(posedge clk or posedge reset)
    if (reset) value <= LFSR_SEED;
    else value <= {value[6:0], ^(value & LFSR_TAPS)};
endmodule

// File: rtl/enemy_controller.sv
// enemy_controller: falling-enemy game FSM tracking position, lives, score and crash timing
module enemy_controller
  import enemy_controller_pkg::*;
#(
  parameter int SPEED        = 4,
  parameter int SCREEN_H     = 480,
  parameter int CRASH_FRAMES = 60,
  parameter int LIVES_INIT   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] enemy_pos_x,
  output logic [9:0] enemy_pos_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       crashing,
  output logic       game_over
);
  localparam int CW = $clog2(CRASH_FRAMES + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] x_n, y_n, lane;
  logic [1:0] lives_n;
  logic [7:0] score_n, lfsr;
  logic unused_lfsr;
  enemy_lfsr u_lfsr (.clk(clk), .reset(reset), .value(lfsr));
  assign unused_lfsr = ^lfsr[7:2];
  assign lane = lane_x(lfsr[1:0]);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = enemy_pos_x;
    y_n     = enemy_pos_y;
    lives_n = lives;
    score_n = score;
    case (state)
      IDLE, OVER:
        if (start) begin
          state_n = RUN;
          lives_n = LIVES_INIT[1:0];
          score_n = '0;
          y_n     = '0;
          x_n     = lane;
        end
      RUN:
        // collision outranks a same-cycle frame_tick, freezing the enemy in place
        if (collision) begin
          state_n = CRASH;
          lives_n = lives - 2'(lives != 2'd0);
          cnt_n   = CRASH_FRAMES[CW-1:0];
        end else if (frame_tick) begin
          if (enemy_pos_y >= 10'(SCREEN_H - SPEED)) begin
            y_n     = '0;
            x_n     = lane;
            score_n = score + 8'(score != 8'hFF);
          end else begin
            y_n = enemy_pos_y + SPEED[9:0];
          end
        end
      CRASH:
        if (frame_tick) begin
          cnt_n = cnt <= CW'(1) ? '0 : cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state_n = lives == 2'd0 ? OVER : RUN;
            y_n     = lives == 2'd0 ? enemy_pos_y : '0;
            x_n     = lives == 2'd0 ? enemy_pos_x : lane;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      enemy_pos_x <= LANE0_X;
      enemy_pos_y <= '0;
      lives       <= '0;
      score       <= '0;
      crashing    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      enemy_pos_x <= x_n;
      enemy_pos_y <= y_n;
      lives       <= lives_n;
      score       <= score_n;
      crashing    <= state_n == CRASH;
      game_over   <= state_n == OVER;
    end
endmodule

// File: tb/tb_enemy_controller.sv
// tb_enemy_controller: directed + randomized checks against a behavioural game model
module tb_enemy_controller;
  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start = 1'b0, collision = 1'b0;
  logic [9:0] enemy_pos_x, enemy_pos_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic crashing, game_over;
  int checks = 0, failures = 0;
  string m_mode;
  int m_x, m_y, m_lives, m_score, m_left;
  int m_rng;

  enemy_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .collision(collision),
    .enemy_pos_x(enemy_pos_x), .enemy_pos_y(enemy_pos_y), .lives(lives), .score(score),
    .crashing(crashing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = "idle"; m_x = 160; m_y = 0; m_lives = 0; m_score = 0; m_left = 0; m_rng = 'hA5;
  endtask

  task automatic model_spawn();
    m_y = 0;
    m_x = 160 + 100 * (m_rng % 4);
  endtask

  task automatic model_step(input bit f, input bit s, input bit c);
    if ((m_mode == "idle" || m_mode == "over") && s) begin
      m_mode = "run"; m_lives = 3; m_score = 0; model_spawn();
    end else if (m_mode == "run" && c) begin
      m_mode = "crash"; m_lives = m_lives > 0 ? m_lives - 1 : 0; m_left = 60;
    end else if (m_mode == "run" && f) begin
      if (m_y + 4 >= 480) begin
        model_spawn();
        m_score = m_score < 255 ? m_score + 1 : 255;
      end else m_y = m_y + 4;
    end else if (m_mode == "crash" && f) begin
      m_left--;
      if (m_left == 0) begin
        if (m_lives == 0) m_mode = "over";
        else begin m_mode = "run"; model_spawn(); end
      end
    end
    m_rng = ((m_rng * 2) % 256) + ($countones(m_rng & 'hB8) % 2);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x"}, enemy_pos_x, m_x);
    check({tag, ".y"}, enemy_pos_y, m_y);
    check({tag, ".lives"}, lives, m_lives);
    check({tag, ".score"}, score, m_score);
    check({tag, ".crashing"}, crashing, m_mode == "crash");
    check({tag, ".game_over"}, game_over, m_mode == "over");
  endtask

  task automatic step(input string tag, input bit f, input bit s, input bit c);
    frame_tick = f; start = s; collision = c;
    @(posedge clk);
    model_step(f, s, c);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #7;
    compare_all("reset");
    #5 reset = 1'b0;
    repeat (3) step("idle_nostart", 1'b1, 1'b0, 1'b0);
    step("start", 1'b0, 1'b1, 1'b0);
    check("start_lives", lives, 3);
    check("start_lane", enemy_pos_x inside {10'd160, 10'd260, 10'd360, 10'd460}, 1);
    for (int i = 0; i < 119; i++) step("run", 1'b1, i == 5, 1'b0);
    check("y_before_wrap", enemy_pos_y, 476);
    step("wrap", 1'b1, 1'b0, 1'b0);
    check("wrap_y", enemy_pos_y, 0);
    check("wrap_score", score, 1);
    for (int i = 0; i < 25; i++) step("to100", 1'b1, 1'b0, 1'b0);
    check("y_at_100", enemy_pos_y, 100);
    step("hit", 1'b1, 1'b0, 1'b1);
    check("hit_crashing", crashing, 1);
    check("hit_y_hold", enemy_pos_y, 100);
    check("hit_lives", lives, 2);
    check("hit_score", score, 1);
    for (int i = 0; i < 59; i++) step("crash", 1'b1, i == 3, 1'b1);
    check("crash_59_still", crashing, 1);
    step("crash_end", 1'b1, 1'b0, 1'b1);
    check("recover_crashing", crashing, 0);
    check("recover_y", enemy_pos_y, 0);
    check("recover_lives", lives, 2);
    for (int k = 0; k < 2; k++) begin
      step("hit2", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) step("crash2", 1'b1, 1'b0, 1'b0);
    end
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    repeat (5) step("over_hold", 1'b1, 1'b0, 1'b1);
    step("restart", 1'b0, 1'b1, 1'b0);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);
    check("restart_over", game_over, 0);
    for (int i = 0; i < 255 * 120; i++) step("sat", 1'b1, 1'b0, 1'b0);
    check("score_255", score, 255);
    for (int i = 0; i < 120; i++) step("sat_hold", 1'b1, 1'b0, 1'b0);
    check("score_stays_255", score, 255);
    step("hit3", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("crash3", 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_reset");
    #2 reset = 1'b0;
    repeat (4) step("post_reset_idle", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++)
      step("rand", $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
